// File: rtl/aes_iter_encrypt_pkg.sv
// Shared AES helpers: FSM encoding, round-count derivation, GF(2^8) arithmetic,
// S-box, Rcon table and the byte-level round transforms.
package aes_iter_encrypt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  function automatic logic [3:0] aes_nr(input int unsigned key_bits);
    return (key_bits == 32'd256) ? 4'd14 : 4'd10;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte i of the state lives at bits [127-8i -: 8]; byte i is row i%4, column i/4.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_iter_encrypt_key_step.sv
// On-the-fly key expansion step: derives the round key for round rnd_i from the
// registered key window and produces the window for the following round.
module aes_iter_encrypt_key_step
  import aes_iter_encrypt_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic [KEY_BITS-1:0] win_i,
  input  logic [3:0]          rnd_i,
  output logic [KEY_BITS-1:0] win_next_o,
  output logic [127:0]        rkey_o
);

  logic [31:0]  tmp_s;
  logic [127:0] new_s;

  if (KEY_BITS == 256) begin : g_k256
    // Window holds w[4r-4 .. 4r+3]; the upper half is round key r-1, the lower half
    // is round key r. New words start at i = 4r+4: odd rnd means i mod 8 == 0.
    assign tmp_s = rnd_i[0] ? (sub_word(rot_word(win_i[31:0])) ^
                               {rcon((rnd_i - 4'd1) >> 1), 24'h000000})
                            : sub_word(win_i[31:0]);
    assign new_s[127:96] = win_i[255:224] ^ tmp_s;
    assign new_s[95:64]  = win_i[223:192] ^ new_s[127:96];
    assign new_s[63:32]  = win_i[191:160] ^ new_s[95:64];
    assign new_s[31:0]   = win_i[159:128] ^ new_s[63:32];
    assign rkey_o        = win_i[127:0];
    assign win_next_o    = {win_i[127:0], new_s};
  end else begin : g_k128
    // Window holds round key r-1; Rcon step index is rnd-1.
    assign tmp_s = sub_word(rot_word(win_i[31:0])) ^ {rcon(rnd_i - 4'd1), 24'h000000};
    assign new_s[127:96] = win_i[127:96] ^ tmp_s;
    assign new_s[95:64]  = win_i[95:64]  ^ new_s[127:96];
    assign new_s[63:32]  = win_i[63:32]  ^ new_s[95:64];
    assign new_s[31:0]   = win_i[31:0]   ^ new_s[63:32];
    assign rkey_o        = new_s;
    assign win_next_o    = new_s;
  end

endmodule

// File: rtl/aes_iter_encrypt.sv
// Iterative AES-128/256 encryption engine, one round per clock with valid/ready
// handshakes. Build option AES_ITER_ZEROIZE_EN clears state, key and output after transfer.
module aes_iter_encrypt
  import aes_iter_encrypt_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  localparam int unsigned NK = KEY_BITS / 32;
  localparam logic [3:0]  NR = aes_nr(KEY_BITS);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_encrypt: KEY_BITS must be 128 or 256");
  end

  aes_state_e          state_q, state_d;
  logic [3:0]          rnd_q, rnd_d;
  logic [127:0]        blk_q, blk_d;
  logic [KEY_BITS-1:0] win_q, win_d;
  logic [127:0]        out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q;

  logic [KEY_BITS-1:0] win_next_s;
  logic [127:0]        rkey_s;
  logic [127:0]        sr_s;
  logic [127:0]        mc_s;
  logic [127:0]        round_s;
  logic                accept_s;
  logic                xfer_s;

  aes_iter_encrypt_key_step #(
    .KEY_BITS (KEY_BITS)
  ) u_key_step (
    .win_i      (win_q),
    .rnd_i      (rnd_q),
    .win_next_o (win_next_s),
    .rkey_o     (rkey_s)
  );

  assign sr_s    = shift_rows(sub_bytes(blk_q));
  assign mc_s    = (rnd_q == NR) ? sr_s : mix_columns(sr_s);
  assign round_s = mc_s ^ rkey_s;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign xfer_s    = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

  // Next-state logic; an accept overrides the per-state update so DONE can chain
  // straight into ROUND without an idle cycle.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    blk_d       = blk_q;
    win_d       = win_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_ROUND: begin
        blk_d = round_s;
        win_d = win_next_s;
        if (rnd_q == NR) begin
          out_data_d  = round_s;
          out_valid_d = 1'b1;
          rnd_d       = 4'd0;
          state_d     = ST_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (xfer_s) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
`ifdef AES_ITER_ZEROIZE_EN
          blk_d      = 128'd0;
          win_d      = '0;
          out_data_d = 128'd0;
`endif
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rnd_d       = 4'd0;
        out_valid_d = 1'b0;
      end
    endcase
    if (accept_s) begin
      blk_d   = in_data ^ in_key[32*NK-1 -: 128];
      win_d   = in_key;
      rnd_d   = 4'd1;
      state_d = ST_ROUND;
    end else begin
      rnd_d = rnd_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rnd_q       <= 4'd0;
      blk_q       <= 128'd0;
      win_q       <= '0;
      out_data_q  <= 128'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      blk_q       <= blk_d;
      win_q       <= win_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= (state_d == ST_ROUND);
    end
  end

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Directed bench for aes_iter_encrypt (AES-128 and AES-256 instances) with a
// ciphertext scoreboard; honours AES_ITER_ZEROIZE_EN for the post-transfer checks.
module tb_aes_iter_encrypt;

`ifdef AES_ITER_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_in_data, a_out_data;
  logic [127:0] a_in_key;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [127:0] b_in_data, b_out_data;
  logic [255:0] b_in_key;

  logic [127:0] sb_a[$];
  logic [127:0] sb_b[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_iter_encrypt #(.KEY_BITS(128)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_key(a_in_key),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  aes_iter_encrypt #(.KEY_BITS(256)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_key(b_in_key),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents a block, checks in_ready, pushes the expected result
  // and returns just after the accepting edge with the inputs scrambled.
  task automatic send(input bit sel, input logic [255:0] key, input logic [127:0] pt,
                      input logic [127:0] ct, input string tag);
    if (sel) begin
      b_in_valid = 1'b1; b_in_key = key; b_in_data = pt;
    end else begin
      a_in_valid = 1'b1; a_in_key = key[127:0]; a_in_data = pt;
    end
    #1;
    check({tag, "_in_ready"}, {127'd0, sel ? b_in_ready : a_in_ready}, 128'd1);
    if (sel) sb_b.push_back(ct);
    else     sb_a.push_back(ct);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0; a_in_data = ~a_in_data; a_in_key = ~a_in_key;
    b_in_valid = 1'b0; b_in_data = ~b_in_data; b_in_key = ~b_in_key;
  endtask

  // Follows one block from its accept edge to out_valid, checking latency and result.
  task automatic run_block(input bit sel, input int exp_lat, input logic [127:0] hold_exp,
                           input bit noise, input string tag);
    int lat;
    logic [127:0] exp;
    lat = 0;
    @(negedge clk);
    check({tag, "_busy"},     {127'd0, sel ? b_busy : a_busy},         128'd1);
    check({tag, "_rdy_low"},  {127'd0, sel ? b_in_ready : a_in_ready}, 128'd0);
    check({tag, "_vld_low"},  {127'd0, sel ? b_out_valid : a_out_valid}, 128'd0);
    check({tag, "_out_hold"}, sel ? b_out_data : a_out_data,           hold_exp);
    if (noise) begin
      a_in_valid = !sel; a_in_data = 128'hdeadbeef; a_in_key = 128'hfeedface;
      b_in_valid = sel;  b_in_data = 128'hdeadbeef; b_in_key = 256'hfeedface;
    end
    while (!(sel ? b_out_valid : a_out_valid) && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 3) begin
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
      end
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    exp = sel ? sb_b.pop_front() : sb_a.pop_front();
    check({tag, "_ct"}, sel ? b_out_data : a_out_data, exp);
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 128'd0; a_in_key = 128'd0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 128'd0; b_in_key = 256'd0; b_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {127'd0, a_out_valid}, 128'd0);
    check("rst_out_data",  a_out_data,            128'd0);
    check("rst_busy",      {127'd0, a_busy},      128'd0);
    check("rst_b_valid",   {127'd0, b_out_valid}, 128'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready",   {127'd0, a_in_ready}, 128'd1);
    check("rst_b_in_ready", {127'd0, b_in_ready}, 128'd1);
    @(negedge clk);

    send(1'b0, {128'd0, K1}, P1, C1, "v1");
    run_block(1'b0, 10, 128'd0, 1'b0, "v1");

    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid",    {127'd0, a_out_valid}, 128'd1);
      check("bp_data",     a_out_data,            C1);
      check("bp_in_ready", {127'd0, a_in_ready},  128'd0);
      check("bp_busy",     {127'd0, a_busy},      128'd0);
    end

    a_out_ready = 1'b1;
    send(1'b0, {128'd0, K2}, P2, C2, "b2b");
    run_block(1'b0, 10, ZEROIZE ? 128'd0 : C1, 1'b1, "b2b");
    @(posedge clk);
    @(negedge clk);
    check("xfer_valid",    {127'd0, a_out_valid}, 128'd0);
    check("xfer_in_ready", {127'd0, a_in_ready},  128'd1);
    check("xfer_out_data", a_out_data,            ZEROIZE ? 128'd0 : C2);

    send(1'b0, {128'd0, K1}, P1, C1, "mid");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    sb_a.delete();
    #1;
    check("mid_rst_valid",    {127'd0, a_out_valid}, 128'd0);
    check("mid_rst_in_ready", {127'd0, a_in_ready},  128'd1);
    check("mid_rst_busy",     {127'd0, a_busy},      128'd0);
    check("mid_rst_data",     a_out_data,            128'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | a_out_valid;
    end
    check("mid_rst_no_spurious", {127'd0, seen}, 128'd0);

    send(1'b0, {128'd0, K2}, P2, C2, "post");
    run_block(1'b0, 10, 128'd0, 1'b1, "post");
    @(posedge clk);
    @(negedge clk);
    check("post_valid_low", {127'd0, a_out_valid}, 128'd0);

    send(1'b1, K3, P2, C3, "a256");
    run_block(1'b1, 14, 128'd0, 1'b0, "a256");
    b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("a256_valid_low", {127'd0, b_out_valid}, 128'd0);
    check("a256_out_data",  b_out_data,            ZEROIZE ? 128'd0 : C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
